bank_write_ctrl: RTL and testbench
==================================

// Module: bank_write_ctrl
// PURPOSE
//  Bus-side write controller that feeds the cartridge's bank/control data registers.
//  Decodes qualified CPU writes in the $FFxx I/O window and drives one shared data bus plus per-register enables.
//  Bank-register writes are gated by a two-byte unlock sequence with an inactivity timeout.
//  Sits between the synchronised CoCo bus front end and the register instances (ctrl, bank_lo, bank_hi).
// PARAMETERS
//  BASE     4'h4   $FFxx low-nibble window select (compared with addr[7:4])
//  KEY1     8'h55  first unlock byte
//  KEY2     8'hAA  second unlock byte
//  TIMEOUT  4095   clock cycles UNLOCKED may idle before auto-relock (1..65535)
// PORTS
//  clock     in   1  system clock; all state updates on posedge
//  reset     in   1  synchronous, active-high
//  strobe    in   1  one-cycle pulse qualifying the current bus cycle
//  io_sel    in   1  CPU address is in $FF00-$FFFF
//  addr      in   8  CPU address low byte
//  rw        in   1  1 = read, 0 = write
//  data_in   in   8  CPU data bus
//  q_ctrl    in   8  readback from ctrl register
//  q_lo      in   8  readback from bank_lo register
//  q_hi      in   8  readback from bank_hi register
//  reg_d     out  8  data to all registers
//  ctrl_en   out  1  enable for ctrl register (offset 0)
//  lo_en     out  1  enable for bank_lo register (offset 1)
//  hi_en     out  1  enable for bank_hi register (offset 2)
//  unlocked  out  1  bank writes currently permitted
//  data_out  out  8  read data
//  data_oe   out  1  drive data_out onto the CPU bus
// BEHAVIOUR
//  - hit = strobe & io_sel & (addr[7:4]==BASE) & (addr[3:2]==0). off = addr[1:0]; off 3 = KEY port.
//  - Write = hit & ~rw. Only write cycles advance the FSM.
//  - Reset values: reg_d=0, *_en=0, unlocked=0, FSM=LOCKED, timer=0, data_oe=0, data_out=0.
//  - Enables and reg_d are registered: asserted exactly 1 cycle after the strobe, for 1 cycle only.
//  - reg_d holds the last written value between writes. Registers capture on the negedge inside the enable cycle.
//  - off 0: ctrl_en pulses in any FSM state.
//  - off 1/2: lo_en/hi_en pulse only when FSM=UNLOCKED. Otherwise the write is dropped silently and reg_d is unchanged.
//  - FSM states: LOCKED, ARMED, UNLOCKED.
//    LOCKED: KEY write with KEY1 -> ARMED. All other writes -> LOCKED.
//    ARMED: KEY write with KEY2 -> UNLOCKED. Any other write (any offset or value) -> LOCKED. Reads do not disturb ARMED.
//    UNLOCKED: KEY write (any value) -> LOCKED. Timer expiry -> LOCKED.
//  - unlocked = (FSM==UNLOCKED), registered.
//  - Timer: loaded with TIMEOUT on entry to UNLOCKED and on every off 1/2 write.
//    Decrements each cycle otherwise. Leaves UNLOCKED on the cycle it would reach 0.
//  - Simultaneous bank write and expiry: the write wins. The enable pulses and the timer reloads.
//  - reset mid-sequence: ARMED or UNLOCKED returns to LOCKED. Any pending enable pulse is cancelled that cycle.
//  - Non-hit strobes and cycles with strobe=0 change nothing except the timer.
// CONFIGURATION
//  BANK_READBACK_EN defined:
//    data_oe = io_sel & rw & addr in window (combinational, no strobe needed).
//    data_out mux: off 0 q_ctrl, off 1 q_lo, off 2 q_hi, off 3 {7'b0, unlocked}.
//  BANK_READBACK_EN undefined:
//    data_oe=0 and data_out=0 constant. q_* inputs are unused. Write path is unchanged.
// TESTING
//  1 reset, write $FF41=$12 -> no lo_en, unlocked=0, reg_d stays 0
//  2 write $FF43=$55, $FF43=$AA, $FF41=$12 -> unlocked=1; lo_en 1-cycle pulse 1 clk after strobe, reg_d=$12
//  3 $FF43=$55, $FF42=$07, $FF43=$AA -> stays LOCKED, no hi_en
//  4 unlock, idle TIMEOUT cycles -> unlocked falls; bank write on the expiry cycle -> pulse issued, stays unlocked
//  5 ctrl write $FF40=$81 while LOCKED -> ctrl_en pulse, reg_d=$81; reset asserted while ARMED -> LOCKED
//  6 (BANK_READBACK_EN) q_hi=$3C, read $FF42 -> data_oe=1, data_out=$3C; read $FF43 unlocked -> $01

Source files
------------

// File: rtl/bank_write_ctrl.sv
// ============================================================================
// Module      : bank_write_ctrl
// Description : Decodes CPU writes in the $FFxx window into a shared data bus
//               and per-register enable pulses, with a key-unlocked bank path.
//               Optional feature macro: BANK_READBACK_EN (register readback).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_write_ctrl #(
  parameter logic [3:0] BASE    = 4'h4,
  parameter logic [7:0] KEY1    = 8'h55,
  parameter logic [7:0] KEY2    = 8'hAA,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       strobe,
  input  logic       io_sel,
  input  logic [7:0] addr,
  input  logic       rw,
  input  logic [7:0] data_in,
  input  logic [7:0] q_ctrl,
  input  logic [7:0] q_lo,
  input  logic [7:0] q_hi,
  output logic [7:0] reg_d,
  output logic       ctrl_en,
  output logic       lo_en,
  output logic       hi_en,
  output logic       unlocked,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_ARMED    = 2'd1,
    ST_UNLOCKED = 2'd2
  } state_t;

  localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_timer, w_timer_nxt;
  logic [7:0]  r_reg_d, w_reg_d_nxt;
  logic        r_ctrl_en, r_lo_en, r_hi_en, r_unlocked;
  logic        w_ctrl_en_nxt, w_lo_en_nxt, w_hi_en_nxt;

  logic       w_in_window;
  logic       w_hit;
  logic       w_wr;
  logic [1:0] w_off;
  logic       w_key_wr;
  logic       w_bank_wr;

  assign w_in_window = io_sel && (addr[7:4] == BASE) && (addr[3:2] == 2'b00);
  assign w_hit       = strobe && w_in_window;
  assign w_wr        = w_hit && !rw;
  assign w_off       = addr[1:0];
  assign w_key_wr    = w_wr && (w_off == 2'd3);
  assign w_bank_wr   = w_wr && ((w_off == 2'd1) || (w_off == 2'd2)) &&
                       (r_state == ST_UNLOCKED);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    unique case (r_state)
      ST_LOCKED: begin
        w_timer_nxt = '0;
        if (w_key_wr && (data_in == KEY1)) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        w_timer_nxt = '0;
        if (w_wr) begin
          if (w_key_wr && (data_in == KEY2)) begin
            w_state_nxt = ST_UNLOCKED;
            w_timer_nxt = TIMER_LOAD;
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end
      end
      ST_UNLOCKED: begin
        // A bank write on the expiry cycle keeps the window open.
        if (w_key_wr) begin
          w_state_nxt = ST_LOCKED;
          w_timer_nxt = '0;
        end else if (w_bank_wr) begin
          w_timer_nxt = TIMER_LOAD;
        end else if (r_timer <= 16'd1) begin
          w_state_nxt = ST_LOCKED;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_LOCKED;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_ctrl_en_nxt = w_wr && (w_off == 2'd0);
    w_lo_en_nxt   = w_bank_wr && (w_off == 2'd1);
    w_hi_en_nxt   = w_bank_wr && (w_off == 2'd2);
    w_reg_d_nxt   = r_reg_d;
    if (w_ctrl_en_nxt || w_bank_wr) begin
      w_reg_d_nxt = data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_LOCKED;
      r_timer    <= '0;
      r_reg_d    <= '0;
      r_ctrl_en  <= 1'b0;
      r_lo_en    <= 1'b0;
      r_hi_en    <= 1'b0;
      r_unlocked <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_reg_d    <= w_reg_d_nxt;
      r_ctrl_en  <= w_ctrl_en_nxt;
      r_lo_en    <= w_lo_en_nxt;
      r_hi_en    <= w_hi_en_nxt;
      r_unlocked <= (w_state_nxt == ST_UNLOCKED);
    end
  end

  assign reg_d    = r_reg_d;
  assign ctrl_en  = r_ctrl_en;
  assign lo_en    = r_lo_en;
  assign hi_en    = r_hi_en;
  assign unlocked = r_unlocked;

`ifdef BANK_READBACK_EN
  logic [7:0] w_rd_mux;

  always_comb begin
    unique case (w_off)
      2'd0:    w_rd_mux = q_ctrl;
      2'd1:    w_rd_mux = q_lo;
      2'd2:    w_rd_mux = q_hi;
      default: w_rd_mux = {7'b0, r_unlocked};
    endcase
  end

  assign data_oe  = w_in_window && rw;
  assign data_out = w_rd_mux;
`else
  logic w_unused_q;
  assign w_unused_q = ^{q_ctrl, q_lo, q_hi};

  assign data_oe  = 1'b0;
  assign data_out = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bank_write_ctrl.sv
// ============================================================================
// Module      : tb_bank_write_ctrl
// Description : Directed self-checking bench for bank_write_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bank_write_ctrl;

  localparam int unsigned T = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       strobe = 1'b0;
  logic       io_sel = 1'b0;
  logic [7:0] addr = 8'h00;
  logic       rw = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [7:0] q_ctrl = 8'h00;
  logic [7:0] q_lo = 8'h00;
  logic [7:0] q_hi = 8'h00;
  logic [7:0] reg_d;
  logic       ctrl_en, lo_en, hi_en, unlocked;
  logic [7:0] data_out;
  logic       data_oe;

  int n_cmp = 0;
  int n_err = 0;

  bank_write_ctrl #(
    .BASE(4'h4), .KEY1(8'h55), .KEY2(8'hAA), .TIMEOUT(T)
  ) dut (
    .clock(clock), .reset(reset), .strobe(strobe), .io_sel(io_sel),
    .addr(addr), .rw(rw), .data_in(data_in),
    .q_ctrl(q_ctrl), .q_lo(q_lo), .q_hi(q_hi),
    .reg_d(reg_d), .ctrl_en(ctrl_en), .lo_en(lo_en), .hi_en(hi_en),
    .unlocked(unlocked), .data_out(data_out), .data_oe(data_oe)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One strobed bus cycle; returns 1 time unit after the qualifying edge.
  task automatic cyc(input logic [7:0] a, input logic [7:0] d, input logic r,
                     input logic io, input logic rst_v);
    @(negedge clock);
    strobe  = 1'b1;
    io_sel  = io;
    addr    = a;
    rw      = r;
    data_in = d;
    reset   = rst_v;
    @(posedge clock);
    #1;
    strobe  = 1'b0;
    io_sel  = 1'b0;
    rw      = 1'b1;
    reset   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cyc(a, d, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    check("rst_reg_d", reg_d, 8'h00);
    check("rst_ctrl_en", {7'b0, ctrl_en}, 8'h00);
    check("rst_lo_en", {7'b0, lo_en}, 8'h00);
    check("rst_hi_en", {7'b0, hi_en}, 8'h00);
    check("rst_unlocked", {7'b0, unlocked}, 8'h00);
    check("rst_data_oe", {7'b0, data_oe}, 8'h00);
    check("rst_data_out", data_out, 8'h00);

    // Locked bank write is dropped
    wr(8'h41, 8'h12);
    check("t1_lo_en", {7'b0, lo_en}, 8'h00);
    check("t1_unlocked", {7'b0, unlocked}, 8'h00);
    check("t1_reg_d", reg_d, 8'h00);

    // Unlock and bank write
    wr(8'h43, 8'h55);
    check("t2_armed_unl", {7'b0, unlocked}, 8'h00);
    wr(8'h43, 8'hAA);
    check("t2_unlocked", {7'b0, unlocked}, 8'h01);
    wr(8'h41, 8'h12);
    check("t2_lo_en", {7'b0, lo_en}, 8'h01);
    check("t2_reg_d", reg_d, 8'h12);
    tick();
    check("t2_lo_en_off", {7'b0, lo_en}, 8'h00);
    check("t2_reg_d_hold", reg_d, 8'h12);
    wr(8'h43, 8'h00);
    check("t2_key_relock", {7'b0, unlocked}, 8'h00);

    // Interrupted sequence stays locked
    wr(8'h43, 8'h55);
    wr(8'h42, 8'h07);
    check("t3_hi_en", {7'b0, hi_en}, 8'h00);
    check("t3_reg_d", reg_d, 8'h12);
    wr(8'h43, 8'hAA);
    check("t3_locked", {7'b0, unlocked}, 8'h00);

    // Read does not disturb ARMED
    wr(8'h43, 8'h55);
    cyc(8'h41, 8'h00, 1'b1, 1'b1, 1'b0);
    wr(8'h43, 8'hAA);
    check("t3_read_armed", {7'b0, unlocked}, 8'h01);
    wr(8'h43, 8'hFF);
    check("t3_relock", {7'b0, unlocked}, 8'h00);

    // Out-of-window key write does not arm
    wr(8'h47, 8'h55);
    wr(8'h43, 8'hAA);
    check("nohit_locked", {7'b0, unlocked}, 8'h00);

    // Timeout: UNLOCKED lasts exactly T cycles
    wr(8'h43, 8'h55);
    wr(8'h43, 8'hAA);
    repeat (T - 1) tick();
    check("t4_before_exp", {7'b0, unlocked}, 8'h01);
    tick();
    check("t4_expired", {7'b0, unlocked}, 8'h00);

    // Bank write on expiry cycle wins and reloads
    wr(8'h43, 8'h55);
    wr(8'h43, 8'hAA);
    repeat (T - 1) tick();
    wr(8'h42, 8'h5A);
    check("t4_exp_hi_en", {7'b0, hi_en}, 8'h01);
    check("t4_exp_unl", {7'b0, unlocked}, 8'h01);
    check("t4_exp_reg_d", reg_d, 8'h5A);
    tick();
    check("t4_hi_en_off", {7'b0, hi_en}, 8'h00);
    repeat (T - 2) tick();
    check("t4_reload_hold", {7'b0, unlocked}, 8'h01);
    tick();
    check("t4_reload_exp", {7'b0, unlocked}, 8'h00);

    // Ctrl write while locked
    wr(8'h40, 8'h81);
    check("t5_ctrl_en", {7'b0, ctrl_en}, 8'h01);
    check("t5_reg_d", reg_d, 8'h81);
    tick();
    check("t5_ctrl_en_off", {7'b0, ctrl_en}, 8'h00);

    // Reset while ARMED
    wr(8'h43, 8'h55);
    @(negedge clock);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr(8'h43, 8'hAA);
    check("t5_rst_armed", {7'b0, unlocked}, 8'h00);

    // Reset cancels a pending enable
    wr(8'h43, 8'h55);
    wr(8'h43, 8'hAA);
    cyc(8'h41, 8'h33, 1'b0, 1'b1, 1'b1);
    check("t5_rst_lo_en", {7'b0, lo_en}, 8'h00);
    check("t5_rst_unl", {7'b0, unlocked}, 8'h00);
    check("t5_rst_reg_d", reg_d, 8'h00);

    // Readback path
    wr(8'h43, 8'h55);
    wr(8'h43, 8'hAA);
    @(negedge clock);
    q_ctrl = 8'hC1;
    q_hi   = 8'h3C;
    io_sel = 1'b1;
    rw     = 1'b1;
    addr   = 8'h42;
    #1;
`ifdef BANK_READBACK_EN
    check("t6_oe", {7'b0, data_oe}, 8'h01);
    check("t6_hi", data_out, 8'h3C);
    addr = 8'h43;
    #1;
    check("t6_key_unl", data_out, 8'h01);
    addr = 8'h40;
    #1;
    check("t6_ctrl", data_out, 8'hC1);
    addr = 8'h52;
    #1;
    check("t6_oe_outside", {7'b0, data_oe}, 8'h00);
`else
    check("t6_oe_off", {7'b0, data_oe}, 8'h00);
    check("t6_out_off", data_out, 8'h00);
`endif
    io_sel = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
